// File: rtl/alu_serial_ctrl.sv
// Bit-serial sequencer around a combinational 1-bit ALU slice: shifts operands
// out LSB first, collects result bits, derives Z/C/V and hands off via valid/ready.
module alu_serial_ctrl #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       opcode,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             flag_z,
  output logic             flag_c,
  output logic             flag_v,
  output logic             s_a,
  output logic             s_b,
  output logic             s_cin,
  output logic             s_ainvert,
  output logic             s_bnegate,
  output logic             s_less,
  output logic [1:0]       s_op,
  input  logic             s_result,
  input  logic             s_cout
);

  localparam int CW = $clog2(WIDTH);

  localparam logic [2:0] OP_AND = 3'd0;
  localparam logic [2:0] OP_OR  = 3'd1;
  localparam logic [2:0] OP_ADD = 3'd2;
  localparam logic [2:0] OP_SUB = 3'd3;
  localparam logic [2:0] OP_NOR = 3'd4;
  localparam logic [2:0] OP_SLT = 3'd5;

  localparam logic [1:0] SOP_AND = 2'd0;
  localparam logic [1:0] SOP_OR  = 2'd1;
  localparam logic [1:0] SOP_ADD = 2'd2;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_a_sh;
  logic [WIDTH-1:0] r_b_sh;
  logic [WIDTH-1:0] r_res;
  logic [2:0]       r_op;
  logic             r_carry;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_result;
  logic             r_flag_z;
  logic             r_flag_c;
  logic             r_flag_v;

  logic [1:0]       w_sop;
  logic             w_ainv;
  logic             w_bneg;
  logic             w_arith;
  logic             w_is_slt;
  logic             w_last;
  logic             w_less;
  logic [WIDTH-1:0] w_res_next;
  logic [WIDTH-1:0] w_final;

  // Slice control decode from the latched opcode; reserved codes behave as AND.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    w_sop    = SOP_AND;
    w_ainv   = 1'b0;
    w_bneg   = 1'b0;
    w_arith  = 1'b0;
    w_is_slt = 1'b0;
    case (r_op)
      OP_OR:  w_sop = SOP_OR;
      OP_ADD: begin
        w_sop   = SOP_ADD;
        w_arith = 1'b1;
      end
      OP_SUB: begin
        w_sop   = SOP_ADD;
        w_bneg  = 1'b1;
        w_arith = 1'b1;
      end
      OP_SLT: begin
        w_sop    = SOP_ADD;
        w_bneg   = 1'b1;
        w_arith  = 1'b1;
        w_is_slt = 1'b1;
      end
      OP_NOR: begin
        w_ainv = 1'b1;
        w_bneg = 1'b1;
      end
      default: ;
    endcase
  end

  assign w_last     = (r_cnt == CW'(WIDTH - 1));
  assign w_res_next = {s_result, r_res[WIDTH-1:1]};
  // Signed less-than: MSB of the difference corrected by the overflow bit.
  assign w_less     = s_result ^ (r_carry ^ s_cout);
  assign w_final    = w_is_slt ? {{(WIDTH-1){1'b0}}, w_less} : w_res_next;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    // NOTE: sequential state always uses non-blocking assignment so every
    // flop samples pre-edge values regardless of process ordering.
    else        r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (in_valid)  w_next = RUN;
      RUN:     if (w_last)    w_next = DONE;
      DONE:    if (out_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Datapath
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: the shift registers are reset too, because an abort mid-RUN must
    // leave no stale partial state visible on the outputs.
    if (!rst_n) begin
      r_a_sh   <= '0;
      r_b_sh   <= '0;
      r_res    <= '0;
      r_op     <= OP_AND;
      r_carry  <= 1'b0;
      r_cnt    <= '0;
      r_result <= '0;
      r_flag_z <= 1'b0;
      r_flag_c <= 1'b0;
      r_flag_v <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (in_valid) begin
          r_a_sh  <= a_in;
          r_b_sh  <= b_in;
          r_op    <= opcode;
          r_cnt   <= '0;
          r_carry <= (opcode == OP_SUB) || (opcode == OP_SLT);
        end
        RUN: begin
          r_a_sh  <= r_a_sh >> 1;
          r_b_sh  <= r_b_sh >> 1;
          r_res   <= w_res_next;
          r_carry <= s_cout;
          if (w_last) begin
            r_result <= w_final;
            r_flag_z <= (w_final == '0);
            r_flag_c <= w_arith & s_cout;
            r_flag_v <= w_arith & (r_carry ^ s_cout);
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Output logic
  always_comb begin
    in_ready  = (r_state == IDLE);
    out_valid = (r_state == DONE);
    s_a       = 1'b0;
    s_b       = 1'b0;
    s_cin     = 1'b0;
    s_ainvert = 1'b0;
    s_bnegate = 1'b0;
    s_less    = 1'b0;
    s_op      = SOP_AND;
    if (r_state == RUN) begin
      s_a       = r_a_sh[0];
      s_b       = r_b_sh[0];
      s_cin     = r_carry;
      s_ainvert = w_ainv;
      s_bnegate = w_bneg;
      s_op      = w_sop;
    end
  end

  assign result = r_result;
  assign flag_z = r_flag_z;
  assign flag_c = r_flag_c;
  assign flag_v = r_flag_v;

endmodule

// File: tb/tb_alu_serial_ctrl.sv
// Directed-vector bench for alu_serial_ctrl with a behavioural 1-bit ALU slice.
module tb_alu_serial_ctrl;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [2:0]   opcode;
  logic [W-1:0] a_in;
  logic [W-1:0] b_in;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         flag_z, flag_c, flag_v;
  logic         s_a, s_b, s_cin, s_ainvert, s_bnegate, s_less;
  logic [1:0]   s_op;
  logic         s_result, s_cout;
  logic         w_sa, w_sb;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  alu_serial_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .opcode(opcode),
    .a_in(a_in), .b_in(b_in),
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .flag_z(flag_z), .flag_c(flag_c), .flag_v(flag_v),
    .s_a(s_a), .s_b(s_b), .s_cin(s_cin), .s_ainvert(s_ainvert),
    .s_bnegate(s_bnegate), .s_less(s_less), .s_op(s_op),
    .s_result(s_result), .s_cout(s_cout)
  );

  // 1-bit ALU slice model
  always_comb begin
    w_sa     = s_ainvert ? ~s_a : s_a;
    w_sb     = s_bnegate ? ~s_b : s_b;
    s_result = s_less;
    case (s_op)
      2'd0:    s_result = w_sa & w_sb;
      2'd1:    s_result = w_sa | w_sb;
      2'd2:    s_result = w_sa ^ w_sb ^ s_cin;
      default: s_result = s_less;
    endcase
    s_cout = (w_sa & w_sb) | (w_sa & s_cin) | (w_sb & s_cin);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"},  32'(in_ready),  32'd1);
    check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_result"},    32'(result),    32'd0);
    check({tag, "_flags"},     32'({flag_z, flag_c, flag_v}), 32'd0);
    check({tag, "_slice"},     32'({s_a, s_b, s_cin, s_ainvert, s_bnegate, s_less, s_op}), 32'd0);
  endtask

  // Accept an operation, check slice control and latency, then check outputs in DONE.
  task automatic run_op(input string tag, input logic [2:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [1:0] exp_sop,
                        input logic exp_inv, input logic [W-1:0] exp_res,
                        input logic exp_z, input logic exp_c, input logic exp_v);
    int n;
    check({tag, "_ready"}, 32'(in_ready), 32'd1);
    opcode   = op;
    a_in     = a;
    b_in     = b;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check({tag, "_busy"}, 32'(in_ready), 32'd0);
    check({tag, "_sctl"}, 32'({s_op, s_ainvert, s_bnegate}),
          32'({exp_sop, exp_inv, exp_inv || op == 3'd3 || op == 3'd5}));
    check({tag, "_cin0"}, 32'(s_cin), 32'(op == 3'd3 || op == 3'd5));
    n = 0;
    while (!out_valid && n < 40) begin
      tick();
      n++;
    end
    check({tag, "_lat"},    n, 16);
    check({tag, "_result"}, 32'(result), 32'(exp_res));
    check({tag, "_zcv"},    32'({flag_z, flag_c, flag_v}), 32'({exp_z, exp_c, exp_v}));
  endtask

  task automatic release_op(input string tag);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, "_xfer_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_xfer_ready"}, 32'(in_ready),  32'd1);
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    opcode    = '0;
    a_in      = '0;
    b_in      = '0;
    #12;
    check_reset_outputs("rst");
    rst_n = 1'b1;
    tick();

    run_op("add_ovf", 3'd2, 16'h7FFF, 16'h0001, 2'd2, 1'b0, 16'h8000, 1'b0, 1'b0, 1'b1);
    release_op("add_ovf");
    run_op("sub_eq",  3'd3, 16'h0005, 16'h0005, 2'd2, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0);
    release_op("sub_eq");
    run_op("sub_neg", 3'd3, 16'h0000, 16'h0001, 2'd2, 1'b0, 16'hFFFF, 1'b0, 1'b0, 1'b0);
    release_op("sub_neg");
    run_op("and",     3'd0, 16'hF0F0, 16'hFF00, 2'd0, 1'b0, 16'hF000, 1'b0, 1'b0, 1'b0);
    release_op("and");
    run_op("or",      3'd1, 16'hF0F0, 16'hFF00, 2'd1, 1'b0, 16'hFFF0, 1'b0, 1'b0, 1'b0);
    release_op("or");
    run_op("nor",     3'd4, 16'hF0F0, 16'hFF00, 2'd0, 1'b1, 16'h000F, 1'b0, 1'b0, 1'b0);
    release_op("nor");
    run_op("rsvd",    3'd7, 16'hF0F0, 16'hFF00, 2'd0, 1'b0, 16'hF000, 1'b0, 1'b0, 1'b0);
    release_op("rsvd");
    run_op("slt_lt",  3'd5, 16'h8000, 16'h0001, 2'd2, 1'b0, 16'h0001, 1'b0, 1'b1, 1'b1);
    release_op("slt_lt");
    run_op("slt_ge",  3'd5, 16'h0001, 16'h8000, 2'd2, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
    release_op("slt_ge");

    // Stall in DONE with a competing request that must be ignored.
    run_op("stall", 3'd2, 16'h0003, 16'h0004, 2'd2, 1'b0, 16'h0007, 1'b0, 1'b0, 1'b0);
    opcode   = 3'd2;
    a_in     = 16'hFFFF;
    b_in     = 16'hFFFF;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("stall_valid",  32'(out_valid), 32'd1);
      check("stall_result", 32'(result),    32'h0007);
      check("stall_ready",  32'(in_ready),  32'd0);
    end
    in_valid = 1'b0;
    release_op("stall");
    tick();
    check("stall_idle", 32'(in_ready), 32'd1);
    check("stall_hold", 32'(result),   32'h0007);

    // Asynchronous reset while bit 7 of an ADD is on the slice.
    check("abort_ready", 32'(in_ready), 32'd1);
    opcode   = 3'd2;
    a_in     = 16'h0080;
    b_in     = 16'h0080;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (7) tick();
    check("abort_bit7", 32'({s_a, s_b}), 32'b11);
    #2 rst_n = 1'b0;
    #1;
    check_reset_outputs("abort");
    #3 rst_n = 1'b1;
    tick();
    run_op("post_rst", 3'd2, 16'h1234, 16'h1111, 2'd2, 1'b0, 16'h2345, 1'b0, 1'b0, 1'b0);
    release_op("post_rst");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/alu_serial_ctrl.md
# alu_serial_ctrl

Bit-serial sequencer for the 16-bit CPU datapath. It sits directly upstream and downstream of the combinational 1-bit ALU slice. It accepts a 16-bit operand pair and an opcode, then drives the slice one bit per clock, LSB first, carrying the slice carry-out in a flip-flop. It collects the result bits into a 16-bit result with Z/C/V flags, and hands the result on over a valid/ready handshake.

## Interface
- WIDTH, 16: operand/result width; the bit counter is clog2(WIDTH) bits.
- clk  in  1  rising-edge clock; one clock, all state on this edge.
- rst_n  in  1  reset, asynchronous, active-low.
- in_valid  in  1  operands/opcode valid.
- in_ready  out  1  block can accept (high only in IDLE).
- opcode  in  3  0=AND, 1=OR, 2=ADD, 3=SUB, 4=NOR, 5=SLT, 6/7=reserved (treated as AND).
- a_in, b_in  in  WIDTH  operands.
- out_valid  out  1  result/flags valid.
- out_ready  in  1  consumer accepts.
- result  out  WIDTH  result word.
- flag_z, flag_c, flag_v  out  1  zero, carry-out of MSB, signed overflow.
- s_a, s_b, s_cin, s_ainvert, s_bnegate, s_less  out  1  slice inputs.
- s_op  out  2  slice op select: 0=AND, 1=OR, 2=ADD.
- s_result, s_cout  in  1  slice outputs; combinational from the s_* inputs.

## Operation
- FSM states: IDLE, RUN, DONE. The reset state is IDLE.
- IDLE, in_valid=1:
  - Latch a_in and b_in into shift registers a_sh and b_sh, and latch the opcode.
  - Clear the bit counter to 0.
  - Load the carry register: 1 for SUB/SLT, else 0.
  - Go to RUN.
- Slice control decode, held constant for the whole operation:
  - AND: op=0, ainv=0, bneg=0.
  - OR: op=1, ainv=0, bneg=0.
  - ADD: op=2, ainv=0, bneg=0.
  - SUB and SLT: op=2, ainv=0, bneg=1.
  - NOR: op=0, ainv=1, bneg=1 (~a & ~b).
  - s_less is always 0.
- Slice drive in RUN: s_a=a_sh[0], s_b=b_sh[0], s_cin=carry register.
- Each RUN cycle:
  - Shift a_sh and b_sh right by one.
  - Shift the result register right, with s_result entering the MSB.
  - carry <= s_cout.
  - Increment the counter.
- At counter=WIDTH-1 (last bit):
  - Capture cin_msb = s_cin and cout_msb = s_cout.
  - Go to DONE.
- DONE:
  - out_valid=1. result and flags stay stable until out_ready=1.
  - On out_valid & out_ready, go to IDLE.
- Flags:
  - ADD/SUB: flag_c = cout_msb, flag_v = cin_msb ^ cout_msb.
  - Logic ops: flag_c = 0, flag_v = 0.
  - SLT: result = {WIDTH-1 zeros, sum_msb ^ (cin_msb ^ cout_msb)}; flag_c and flag_v are those of the subtraction.
  - flag_z = (result == 0), evaluated on the final result (after the SLT rewrite).
- Arithmetic is two's complement modulo 2^WIDTH. SUB computes a + ~b + 1.
- Outside RUN, all s_* outputs are driven 0.
- No back-to-back overlap: in_ready is low in RUN and DONE. in_valid in those states is ignored, not queued.

## Timing
- Reset values: in_ready=1, out_valid=0, result=0, flag_z=0, flag_c=0, flag_v=0, all s_*=0, counter=0, FSM=IDLE.
- Reset is asynchronous and may assert mid-RUN or in DONE. The operation is discarded and everything returns to reset values immediately, with no partial output.
- Latency:
  - Accept edge at cycle T.
  - Bits 0..15 are processed at edges T+1..T+16.
  - out_valid is high from cycle T+16 (after the 16th edge).
- Throughput: one operation per WIDTH+2 cycles when out_ready is held high (IDLE and DONE each last at least one cycle).
- Stall: out_valid stays high and result is held unchanged for any number of cycles with out_ready=0.
- The counter wraps WIDTH-1 -> 0 only via the IDLE load. It never free-runs.
- Cycles whose in_valid rises in the same cycle that DONE exits are accepted on the next cycle (in_ready registered from FSM state).

## Test plan
- ADD 0x7FFF + 0x0001 -> result=0x8000, flag_z=0, flag_c=0, flag_v=1, out_valid exactly 16 cycles after accept.
- SUB 0x0005 - 0x0005 -> result=0x0000, flag_z=1, flag_c=1, flag_v=0. Also SUB 0x0000 - 0x0001 -> 0xFFFF, flag_c=0.
- Logic with a=0xF0F0, b=0xFF00 -> AND=0xF000, OR=0xFFF0, NOR=0x000F, flag_c=flag_v=0. Check s_ainvert=s_bnegate=1 only for NOR.
- SLT 0x8000 vs 0x0001 (signed) -> result=0x0001. SLT 0x0001 vs 0x8000 -> 0x0000, flag_z=1.
- Hold out_ready=0 for 5 cycles in DONE -> result stable, in_ready=0, a new in_valid is ignored. Release -> one transfer, then IDLE.
- Assert rst_n=0 at bit 7 of an ADD -> all outputs immediately at reset values. The next operation 0x1234+0x1111 -> 0x2345.
